// File: rtl/accumulator_pkg.sv
// Shared definitions for the accumulator / accumulator_decoder pair.
//   DEFAULT_WIDTH : data width shared with the upstream accumulator
//   ST_*          : encoding of the 2-entry output buffer states
//   buf_state_e   : typed state enum built on that encoding
package accumulator_pkg;

  localparam int unsigned DEFAULT_WIDTH = 16;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;

  typedef enum logic [1:0] {
    StEmpty = ST_EMPTY,
    StOne   = ST_ONE,
    StTwo   = ST_TWO
  } buf_state_e;

endpackage

// File: rtl/accumulator_decoder_if.sv
// Stream bundle around accumulator_decoder.
//   in_data/in_valid/in_first/in_ready : upstream accumulated-value stream
//   out_data/out_valid/out_ready       : downstream recovered-difference stream
// slave  : the decoder's view; master : the driving environment's view.
interface accumulator_decoder_if
  import accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_first;
  logic             in_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;

  modport slave (
    input  in_data, in_valid, in_first, out_ready,
    output in_ready, out_data, out_valid
  );

  modport master (
    output in_data, in_valid, in_first, out_ready,
    input  in_ready, out_data, out_valid
  );
endinterface

// File: rtl/accumulator_decoder_skid_buffer_2.sv
// Two-entry valid/ready buffer with a registered upstream ready.
//   clk, reset : clock, synchronous active-high reset
//   i_valid/i_data/o_ready : upstream side (o_ready is a flop)
//   o_valid/o_data/i_ready : downstream side (o_data/o_valid are flops)
// The skid entry absorbs the beat accepted in the cycle before o_ready drops.
module skid_buffer_2
  import accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data,
  input  logic             i_ready
);

  buf_state_e       r_state;
  logic [WIDTH-1:0] r_out_data;
  logic [WIDTH-1:0] r_skid;
  logic             r_in_ready;

  logic w_accept;
  logic w_pop;

  assign w_accept = i_valid & r_in_ready;
  assign w_pop    = (r_state != StEmpty) & i_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StEmpty;
      r_out_data <= '0;
      r_skid     <= '0;
      r_in_ready <= 1'b1;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_accept) begin
            r_state    <= StOne;
            r_out_data <= i_data;
          end
          r_in_ready <= 1'b1;
        end
        StOne: begin
          if (w_accept && !w_pop) begin
            r_state    <= StTwo;
            r_skid     <= i_data;
            r_in_ready <= 1'b0;
          end else if (w_pop && !w_accept) begin
            r_state    <= StEmpty;
            r_in_ready <= 1'b1;
          end else begin
            if (w_accept) r_out_data <= i_data;
            r_in_ready <= 1'b1;
          end
        end
        StTwo: begin
          // r_in_ready is low here, so only a pop can move us.
          if (w_pop) begin
            r_state    <= StOne;
            r_out_data <= r_skid;
            r_in_ready <= 1'b1;
          end
        end
        default: begin
          r_state    <= StEmpty;
          r_in_ready <= 1'b1;
        end
      endcase
    end
  end

  assign o_ready = r_in_ready;
  assign o_valid = (r_state != StEmpty);
  assign o_data  = r_out_data;

endmodule

// File: rtl/accumulator_decoder.sv
// Recovers increments from a running-sum stream: out = in - previous in (mod 2^WIDTH).
//   clk, reset : clock, synchronous active-high reset
//   bus        : accumulator_decoder_if slave (in_* stream in, out_* stream out)
//   sample_cnt : accepted beats since reset or last in_first, saturating
// in_first zeroes the previous value so the stream can be realigned.
module accumulator_decoder
  import accumulator_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH,
  parameter int unsigned CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  accumulator_decoder_if.slave  bus,
  output logic [CNT_W-1:0]      sample_cnt
);

  logic [WIDTH-1:0] r_history;
  logic [CNT_W-1:0] r_sample_cnt;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_prev;
  logic [WIDTH-1:0] w_diff;

  assign w_accept = bus.in_valid & w_in_ready;
  assign w_prev   = bus.in_first ? '0 : r_history;
  assign w_diff   = bus.in_data - w_prev;  // wraps modulo 2^WIDTH

  always_ff @(posedge clk) begin
    if (reset) begin
      r_history    <= '0;
      r_sample_cnt <= '0;
    end else if (w_accept) begin
      r_history <= bus.in_data;
      if (bus.in_first) begin
        r_sample_cnt <= CNT_W'(1);
      end else if (r_sample_cnt != '1) begin
        r_sample_cnt <= r_sample_cnt + CNT_W'(1);
      end
    end
  end

  skid_buffer_2 #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .i_valid (bus.in_valid),
    .i_data  (w_diff),
    .o_ready (w_in_ready),
    .o_valid (bus.out_valid),
    .o_data  (bus.out_data),
    .i_ready (bus.out_ready)
  );

  assign bus.in_ready = w_in_ready;
  assign sample_cnt   = r_sample_cnt;

endmodule

// File: doc/accumulator_decoder.md
Name: accumulator_decoder

Overview:
- Inverse of the 16-bit running-sum accumulator. Takes a stream of accumulated values and recovers the original increments: out[n] = in[n] - in[n-1], modulo 2^WIDTH.
- Sits downstream of an accumulator stage, or at the far end of a link carrying accumulated values.
- Adds valid/ready flow control with a 2-entry skid buffer, so back-pressure never drops a sample and in_ready is registered.

Parameters:
- WIDTH, 16, data width of input accumulated values and output differences.
- CNT_W, 16, width of the accepted-sample counter.

Ports:
- clk  input  1  single clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- in_data  input  WIDTH  accumulated value.
- in_valid  input  1  in_data valid.
- in_first  input  1  sideband, qualified by an accepted beat: treat previous value as 0 (stream realign).
- in_ready  output  1  block can accept a beat; registered.
- out_data  output  WIDTH  recovered difference.
- out_valid  output  1  out_data valid.
- out_ready  input  1  downstream accepts out_data.
- sample_cnt  output  CNT_W  accepted beats since reset or last in_first; saturating.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. On reset, at the clock edge:
  - state = EMPTY, out_valid = 0, out_data = 0, in_ready = 1;
  - history = 0, skid register = 0, sample_cnt = 0.
- Beat definitions:
  - accept = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Difference on accept:
  - diff = in_data - (in_first ? 0 : history), truncated to WIDTH bits (two's-complement wrap, no saturation, no overflow flag).
  - history <= in_data.
- Because history resets to 0, the first beat after reset outputs in_data unchanged. This matches an accumulator whose register also starts at 0.
- Latency: diff appears on out_data/out_valid the cycle after accept. No combinational path from in_* to out_*.
- Flow control: buffer FSM with states EMPTY, ONE, TWO. out_valid = (state != EMPTY).
  - EMPTY: accept -> ONE, out_data <= diff.
  - ONE, accept & !pop -> TWO, skid <= diff.
  - ONE, pop & !accept -> EMPTY.
  - ONE, accept & pop -> ONE, out_data <= diff.
  - ONE, neither -> ONE.
  - TWO: pop -> ONE, out_data <= skid. No accept is possible in TWO.
- in_ready is registered: next in_ready = !(next state == TWO). Consequence: after accept in ONE without pop, in_ready drops the following cycle; the skid entry absorbs that beat.
- Output hold: out_data and out_valid hold stable while out_valid & !out_ready. Sample order is preserved; no sample is ever dropped or duplicated.
- sample_cnt:
  - +1 per accept, saturating at 2^CNT_W-1.
  - Set to 1 on an accept with in_first = 1.
  - Not affected by pops.
- Ignored inputs:
  - in_first without accept is ignored.
  - in_data and in_valid while in_ready = 0 are ignored; the upstream must hold the beat.
- Reset mid-operation: the buffered contents are discarded, and history returns to 0.
  - In the cycle reset is high, out_valid is forced to 0 at the edge.
  - Any accept or pop in that same cycle has no effect.

Decomposition:
- Shared package accumulator_pkg holds:
  - state encoding localparams ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2;
  - default WIDTH = 16, shared with the accumulator.
- One sub-module, skid_buffer_2: the WIDTH-parameterised 2-entry valid/ready buffer implementing the EMPTY/ONE/TWO FSM.
- The top level holds the history register, the subtractor, in_first muxing and sample_cnt.

Test Plan:
- Reset, then accept 3, 8, 8, 20 with out_ready = 1 -> out_data 3, 5, 0, 12. Each appears one cycle after its accept; sample_cnt = 4.
- Wrap: accept 0xFFFE, then 0x0005 -> second out_data = 0x0007. Then accept 0x0002 -> 0xFFFD.
- Back-pressure: out_ready = 0, offer 10, 30, 60 continuously.
  - 10 and 30 are accepted, in_ready = 0 from the cycle after the second accept, and out_data holds 10.
  - Release out_ready -> outputs 10, 20, 30 in order, with no loss.
- Realign: stream 100, 150, then 400 with in_first = 1 -> outputs 100, 50, 400; sample_cnt = 1 after the third beat.
- Simultaneous accept and pop in state ONE every cycle, inputs 1, 2, 3, 4, 5 -> outputs 1, 1, 1, 1, 1 at full throughput; in_ready stays 1.
- Reset asserted while in TWO holding diffs 7 and 9 -> next cycle out_valid = 0, in_ready = 1.
  - Then accept 4 -> out_data = 4, because history was cleared.
  - sample_cnt = 1.
